// File: rtl/cfg_param_bank_if.sv
// Write / apply / readback bus of cfg_param_bank.
// Optional lock/locked pair when CFG_PARAM_BANK_LOCK_EN is defined.
interface cfg_param_bank_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int ADDR_W   = 2
);
    logic                      wr_valid;
    logic                      wr_ready;
    logic [ADDR_W-1:0]         wr_addr;
    logic [WIDTH-1:0]          wr_data;
    logic                      apply;
    logic [ADDR_W-1:0]         rd_addr;
    logic                      rd_shadow;
    logic [WIDTH-1:0]          rd_data;
    logic [CHANNELS*WIDTH-1:0] cfg_out;
    logic                      pending;
    logic                      done;
    logic                      err;
`ifdef CFG_PARAM_BANK_LOCK_EN
    logic                      lock;
    logic                      locked;

    modport master (
        output wr_valid, wr_addr, wr_data, apply, rd_addr, rd_shadow, lock,
        input  wr_ready, rd_data, cfg_out, pending, done, err, locked
    );
    modport slave (
        input  wr_valid, wr_addr, wr_data, apply, rd_addr, rd_shadow, lock,
        output wr_ready, rd_data, cfg_out, pending, done, err, locked
    );
`else
    modport master (
        output wr_valid, wr_addr, wr_data, apply, rd_addr, rd_shadow,
        input  wr_ready, rd_data, cfg_out, pending, done, err
    );
    modport slave (
        input  wr_valid, wr_addr, wr_data, apply, rd_addr, rd_shadow,
        output wr_ready, rd_data, cfg_out, pending, done, err
    );
`endif
endinterface

// File: rtl/cfg_param_bank.sv
// Multi-channel runtime-tunable parameter bank: shadow writes, apply walk commits dirty channels.
// Optional write/apply lock enabled by defining CFG_PARAM_BANK_LOCK_EN.
module cfg_param_bank #(
    parameter int                          WIDTH    = 8,
    parameter int                          CHANNELS = 4,
    parameter int                          ADDR_W   = 2,
    parameter logic [CHANNELS*WIDTH-1:0]   DEFAULTS = 32'h4B32_190A
) (
    input  logic            clk,
    input  logic            rst_n,
    cfg_param_bank_if.slave cfg_bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        APPLY = 1'b1
    } state_t;

    typedef logic [CHANNELS-1:0][WIDTH-1:0] bank_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(CHANNELS - 1);
    localparam logic [ADDR_W:0]   CH_LIM   = (ADDR_W + 1)'(CHANNELS);

    state_t              state_q,   state_d;
    logic [ADDR_W-1:0]   index_q,   index_d;
    bank_t               shadow_q,  shadow_d;
    bank_t               active_q,  active_d;
    logic [CHANNELS-1:0] dirty_q,   dirty_d;
    logic [WIDTH-1:0]    rd_data_q, rd_data_d;
    logic                done_q,    done_d;
    logic                err_q,     err_d;

    logic wr_fire;
    logic wr_hit;
    logic frozen;

    assign wr_fire = cfg_bus.wr_valid && (state_q == IDLE);
    assign wr_hit  = ({1'b0, cfg_bus.wr_addr} < CH_LIM);

`ifdef CFG_PARAM_BANK_LOCK_EN
    logic locked_q, locked_d;

    // Sticky until reset: once set, nothing but rst_n clears it.
    always_comb locked_d = locked_q | (cfg_bus.lock && (state_q == IDLE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) locked_q <= 1'b0;
        else        locked_q <= locked_d;
    end

    assign frozen         = locked_q;
    assign cfg_bus.locked = locked_q;
`else
    assign frozen = 1'b0;
`endif

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cfg_bus.apply && !frozen) begin
                    state_d = APPLY;
                    index_d = '0;
                end
            end
            APPLY: begin
                if (index_q == LAST_IDX) begin
                    state_d = IDLE;
                    index_d = '0;
                    done_d  = 1'b1;
                end else begin
                    index_d = index_q + ADDR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Writes only land in IDLE and commits only happen in APPLY, so the two never collide.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        dirty_d  = dirty_q;
        err_d    = wr_fire && (frozen || !wr_hit);
        for (int i = 0; i < CHANNELS; i++) begin
            if (wr_fire && !frozen && (cfg_bus.wr_addr == ADDR_W'(i))) begin
                shadow_d[i] = cfg_bus.wr_data;
                dirty_d[i]  = 1'b1;
            end
            if ((state_q == APPLY) && (index_q == ADDR_W'(i)) && dirty_q[i]) begin
                active_d[i] = shadow_q[i];
                dirty_d[i]  = 1'b0;
            end
        end
    end

    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_bus.rd_addr == ADDR_W'(i)) begin
                rd_data_d = cfg_bus.rd_shadow ? shadow_q[i] : active_q[i];
            end
        end
    end

    // NOTE: both banks are flop arrays reset to DEFAULTS, so cfg_out is valid straight out of reset.
    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            index_q   <= '0;
            shadow_q  <= DEFAULTS;
            active_q  <= DEFAULTS;
            dirty_q   <= '0;
            rd_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            dirty_q   <= dirty_d;
            rd_data_q <= rd_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign cfg_bus.wr_ready = (state_q == IDLE);
    assign cfg_bus.rd_data  = rd_data_q;
    assign cfg_bus.cfg_out  = active_q;
    assign cfg_bus.pending  = |dirty_q;
    assign cfg_bus.done     = done_q;
    assign cfg_bus.err      = err_q;

endmodule

// File: tb/tb_cfg_param_bank.sv
// Self-checking bench for cfg_param_bank: table-driven writes on a 3-channel instance,
// hand sequences for apply timing, overlap and reset, readback through a scoreboard queue.
module tb_cfg_param_bank;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    cfg_param_bank_if #(.WIDTH(8), .CHANNELS(4), .ADDR_W(2)) bus_dut ();
    cfg_param_bank_if #(.WIDTH(8), .CHANNELS(4), .ADDR_W(2)) bus_a ();
    cfg_param_bank_if #(.WIDTH(8), .CHANNELS(4), .ADDR_W(2)) bus_b ();
    cfg_param_bank_if #(.WIDTH(8), .CHANNELS(3), .ADDR_W(2)) bus_c ();

    cfg_param_bank #(.WIDTH(8), .CHANNELS(4), .ADDR_W(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .cfg_bus(bus_dut)
    );
    cfg_param_bank #(.WIDTH(8), .CHANNELS(4), .ADDR_W(2), .DEFAULTS(32'h0000_0019)) u_a (
        .clk(clk), .rst_n(rst_n), .cfg_bus(bus_a)
    );
    cfg_param_bank #(.WIDTH(8), .CHANNELS(4), .ADDR_W(2), .DEFAULTS(32'h0000_004B)) u_b (
        .clk(clk), .rst_n(rst_n), .cfg_bus(bus_b)
    );
    cfg_param_bank #(.WIDTH(8), .CHANNELS(3), .ADDR_W(2), .DEFAULTS(24'h32_190A)) u_c (
        .clk(clk), .rst_n(rst_n), .cfg_bus(bus_c)
    );

    typedef struct {
        logic [1:0] wr_addr;
        logic [7:0] wr_data;
        logic       exp_err;
        logic       exp_pending;
        logic [1:0] rd_addr;
        logic [7:0] rd_exp;
    } vec_t;

    vec_t       vecs[5];
    logic [7:0] sb_q[$];
    int         checks   = 0;
    int         failures = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered one cycle after apply was sampled; lat counts cycles from the apply cycle.
    task automatic wait_dut_done(output int lat, output bit seen);
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat <= 20) begin
            if (bus_dut.done === 1'b1) begin
                seen = 1'b1;
            end else begin
                step();
                lat++;
            end
        end
    endtask

    task automatic sb_read_dut(input logic [1:0] addr, input logic shadow, input logic [7:0] exp, input string name);
        bus_dut.rd_addr   = addr;
        bus_dut.rd_shadow = shadow;
        sb_q.push_back(exp);
        step();
        check(name, 32'(bus_dut.rd_data), 32'(sb_q.pop_front()));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit seen;
        int n_done;
        int done_at;

        vecs[0] = '{2'd3, 8'hFF, 1'b1, 1'b0, 2'd2, 8'h32};
        vecs[1] = '{2'd2, 8'h77, 1'b0, 1'b1, 2'd2, 8'h77};
        vecs[2] = '{2'd2, 8'h78, 1'b0, 1'b1, 2'd2, 8'h78};
        vecs[3] = '{2'd0, 8'h01, 1'b0, 1'b1, 2'd0, 8'h01};
        vecs[4] = '{2'd3, 8'h55, 1'b1, 1'b1, 2'd3, 8'h00};

        bus_dut.wr_valid = 1'b0; bus_dut.wr_addr = '0; bus_dut.wr_data = '0;
        bus_dut.apply = 1'b0; bus_dut.rd_addr = '0; bus_dut.rd_shadow = 1'b0;
        bus_a.wr_valid = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
        bus_a.apply = 1'b0; bus_a.rd_addr = '0; bus_a.rd_shadow = 1'b0;
        bus_b.wr_valid = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0;
        bus_b.apply = 1'b0; bus_b.rd_addr = '0; bus_b.rd_shadow = 1'b0;
        bus_c.wr_valid = 1'b0; bus_c.wr_addr = '0; bus_c.wr_data = '0;
        bus_c.apply = 1'b0; bus_c.rd_addr = '0; bus_c.rd_shadow = 1'b0;
`ifdef CFG_PARAM_BANK_LOCK_EN
        bus_dut.lock = 1'b0; bus_a.lock = 1'b0; bus_b.lock = 1'b0; bus_c.lock = 1'b0;
`endif

        // Asynchronous reset: defaults must show before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        check("rst_cfg_out",  32'(bus_dut.cfg_out), 32'h4B32_190A);
        check("rst_pending",  32'(bus_dut.pending), 32'd0);
        check("rst_done",     32'(bus_dut.done),    32'd0);
        check("rst_err",      32'(bus_dut.err),     32'd0);
        check("rst_rd_data",  32'(bus_dut.rd_data), 32'd0);
        check("rst_wr_ready", 32'(bus_dut.wr_ready), 32'd1);
        check("rst_a_cfg",    32'(bus_a.cfg_out),   32'h0000_0019);
        check("rst_b_cfg",    32'(bus_b.cfg_out),   32'h0000_004B);
        check("rst_c_cfg",    32'(bus_c.cfg_out),   32'h0032_190A);
        #1 rst_n = 1'b1;

        bus_dut.rd_addr = 2'd2;
        bus_a.rd_addr   = 2'd0;
        bus_b.rd_addr   = 2'd0;
        step();
        check("rd_active_ch2", 32'(bus_dut.rd_data), 32'd50);
        check("a_rd_ch0",      32'(bus_a.rd_data),   32'd25);
        check("b_rd_ch0",      32'(bus_b.rd_data),   32'd75);

        // Write ch1 = A5, read shadow and active back.
        bus_dut.wr_valid = 1'b1; bus_dut.wr_addr = 2'd1; bus_dut.wr_data = 8'hA5;
        step();
        bus_dut.wr_valid = 1'b0;
        check("wr1_pending", 32'(bus_dut.pending), 32'd1);
        check("wr1_err",     32'(bus_dut.err),     32'd0);
        sb_read_dut(2'd1, 1'b1, 8'hA5, "wr1_rd_shadow");
        sb_read_dut(2'd1, 1'b0, 8'h19, "wr1_rd_active");

        // Apply at t: ch1 visible at t+3, done at t+5.
        bus_dut.apply = 1'b1;
        step();
        bus_dut.apply = 1'b0;
        check("ap1_wr_ready_t1", 32'(bus_dut.wr_ready), 32'd0);
        step();
        check("ap1_ch1_t2", 32'(bus_dut.cfg_out[15:8]), 32'h19);
        step();
        check("ap1_ch1_t3", 32'(bus_dut.cfg_out[15:8]), 32'hA5);
        step();
        check("ap1_done_t4", 32'(bus_dut.done), 32'd0);
        step();
        check("ap1_done_t5",     32'(bus_dut.done),     32'd1);
        check("ap1_pending_t5",  32'(bus_dut.pending),  32'd0);
        check("ap1_wr_ready_t5", 32'(bus_dut.wr_ready), 32'd1);
        step();
        check("ap1_done_t6", 32'(bus_dut.done), 32'd0);

        // Write ch3 and apply together; second apply mid-walk must be ignored.
        bus_dut.wr_valid = 1'b1; bus_dut.wr_addr = 2'd3; bus_dut.wr_data = 8'h11;
        bus_dut.apply = 1'b1;
        step();
        bus_dut.wr_valid = 1'b0;
        bus_dut.apply    = 1'b0;
        check("ap2_pending_t1", 32'(bus_dut.pending), 32'd1);
        n_done  = 0;
        done_at = 0;
        for (int k = 1; k <= 10; k++) begin
            bus_dut.apply = (k == 2);
            if (bus_dut.done === 1'b1) begin
                n_done++;
                done_at = k;
            end
            if (k == 4) check("ap2_ch3_t4", 32'(bus_dut.cfg_out[31:24]), 32'h4B);
            if (k == 5) check("ap2_ch3_t5", 32'(bus_dut.cfg_out[31:24]), 32'h11);
            step();
        end
        bus_dut.apply = 1'b0;
        check("ap2_done_count", 32'(n_done),  32'd1);
        check("ap2_done_cycle", 32'(done_at), 32'd5);
        check("ap2_cfg_out",    32'(bus_dut.cfg_out), 32'h1132_A50A);
        sb_read_dut(2'd3, 1'b0, 8'h11, "ap2_rd_active_ch3");

        // Empty apply still pulses done; apply in the done cycle starts another walk.
        bus_dut.apply = 1'b1;
        step();
        bus_dut.apply = 1'b0;
        wait_dut_done(lat, seen);
        check("ap3_done_seen", 32'(seen), 32'd1);
        check("ap3_latency",   32'(lat),  32'd5);
        bus_dut.apply = 1'b1;
        step();
        bus_dut.apply = 1'b0;
        check("ap4_restart_busy", 32'(bus_dut.wr_ready), 32'd0);
        wait_dut_done(lat, seen);
        check("ap4_done_seen", 32'(seen), 32'd1);
        check("ap4_latency",   32'(lat),  32'd5);
        check("ap4_cfg_out",   32'(bus_dut.cfg_out), 32'h1132_A50A);
        step();

        // Three-channel instance: table of writes, including out-of-range addresses.
        foreach (vecs[i]) begin
            bus_c.wr_valid = 1'b1;
            bus_c.wr_addr  = vecs[i].wr_addr;
            bus_c.wr_data  = vecs[i].wr_data;
            check($sformatf("c_wr_ready[%0d]", i), 32'(bus_c.wr_ready), 32'd1);
            step();
            bus_c.wr_valid = 1'b0;
            check($sformatf("c_err[%0d]", i),     32'(bus_c.err),     32'(vecs[i].exp_err));
            check($sformatf("c_pending[%0d]", i), 32'(bus_c.pending), 32'(vecs[i].exp_pending));
            bus_c.rd_addr   = vecs[i].rd_addr;
            bus_c.rd_shadow = 1'b1;
            sb_q.push_back(vecs[i].rd_exp);
            step();
            check($sformatf("c_rd_shadow[%0d]", i), 32'(bus_c.rd_data), 32'(sb_q.pop_front()));
            check($sformatf("c_err_clear[%0d]", i), 32'(bus_c.err), 32'd0);
        end
        bus_c.apply = 1'b1;
        step();
        bus_c.apply = 1'b0;
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat <= 20) begin
            if (bus_c.done === 1'b1) begin
                seen = 1'b1;
            end else begin
                step();
                lat++;
            end
        end
        check("c_done_seen", 32'(seen), 32'd1);
        check("c_latency",   32'(lat),  32'd4);
        check("c_cfg_out",   32'(bus_c.cfg_out), 32'h0078_1901);
        check("c_pending",   32'(bus_c.pending), 32'd0);

        // Reset in the middle of a walk discards everything.
        bus_dut.wr_valid = 1'b1; bus_dut.wr_addr = 2'd0; bus_dut.wr_data = 8'h01;
        step();
        bus_dut.wr_addr = 2'd2; bus_dut.wr_data = 8'h02;
        step();
        bus_dut.wr_valid = 1'b0;
        bus_dut.apply    = 1'b1;
        step();
        bus_dut.apply = 1'b0;
        step();
        check("rmid_ch0_committed", 32'(bus_dut.cfg_out[7:0]), 32'h01);
        #1 rst_n = 1'b0;
        #1;
        check("rmid_cfg_out",  32'(bus_dut.cfg_out),  32'h4B32_190A);
        check("rmid_pending",  32'(bus_dut.pending),  32'd0);
        check("rmid_wr_ready", 32'(bus_dut.wr_ready), 32'd1);
        check("rmid_done",     32'(bus_dut.done),     32'd0);
        #1 rst_n = 1'b1;
        step();
        sb_read_dut(2'd2, 1'b1, 8'h32, "rmid_rd_shadow_ch2");
        bus_dut.apply = 1'b1;
        step();
        bus_dut.apply = 1'b0;
        wait_dut_done(lat, seen);
        check("rmid_apply_done", 32'(seen), 32'd1);
        check("rmid_cfg_after",  32'(bus_dut.cfg_out), 32'h4B32_190A);
        step();

`ifdef CFG_PARAM_BANK_LOCK_EN
        bus_dut.lock = 1'b1;
        step();
        bus_dut.lock = 1'b0;
        check("lock_locked", 32'(bus_dut.locked), 32'd1);
        bus_dut.wr_valid = 1'b1; bus_dut.wr_addr = 2'd1; bus_dut.wr_data = 8'hEE;
        check("lock_wr_ready", 32'(bus_dut.wr_ready), 32'd1);
        step();
        bus_dut.wr_valid = 1'b0;
        check("lock_err",     32'(bus_dut.err),     32'd1);
        check("lock_pending", 32'(bus_dut.pending), 32'd0);
        sb_read_dut(2'd1, 1'b1, 8'h19, "lock_rd_shadow_ch1");
        bus_dut.apply = 1'b1;
        step();
        bus_dut.apply = 1'b0;
        check("lock_no_apply", 32'(bus_dut.wr_ready), 32'd1);
        wait_dut_done(lat, seen);
        check("lock_no_done", 32'(seen), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cfg_param_bank.md
Name: cfg_param_bank

Overview:
- Parametrised, multi-channel successor to the single-value parameter config block.
- Holds CHANNELS configuration words, each WIDTH bits, with per-channel reset defaults taken from a packed parameter. Defaults are overridable per instance via defparam or #().
- Runtime writes land in a shadow bank. An apply strobe commits dirty channels into the active bank one channel per cycle.
- Sits between the control/test harness and datapath blocks that need per-instance, runtime-tunable constants.

Parameters:
- WIDTH, 8: bits per channel.
- CHANNELS, 4: number of channels, 1..16. Need not be a power of two.
- ADDR_W, 2: address width. Must satisfy 2**ADDR_W >= CHANNELS.
- DEFAULTS, 32'h4B32_190A: packed reset values, CHANNELS*WIDTH bits. Channel i occupies [i*WIDTH +: WIDTH]. Default gives ch0=10, ch1=25, ch2=50, ch3=75.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous reset, active-low.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accept. High only in IDLE.
- wr_addr  in  ADDR_W  write channel index.
- wr_data  in  WIDTH  write value.
- apply  in  1  commit request, sampled in IDLE only.
- rd_addr  in  ADDR_W  readback channel index.
- rd_shadow  in  1  1 = read shadow bank, 0 = read active bank.
- rd_data  out  WIDTH  registered readback.
- cfg_out  out  CHANNELS*WIDTH  active bank, packed like DEFAULTS.
- pending  out  1  OR of all dirty bits.
- done  out  1  one-cycle pulse when apply completes.
- err  out  1  one-cycle pulse on an out-of-range write.

Behaviour:
- Reset (rst_n low, asynchronous):
  - shadow = active = DEFAULTS; dirty = 0; state = IDLE; index = 0.
  - rd_data = 0; done = 0; err = 0.
  - cfg_out therefore equals DEFAULTS with no clock edge required.
  - Reset mid-APPLY discards all writes and partial commits.
- States: IDLE, APPLY. wr_ready = (state == IDLE), combinational.
- Write handshake:
  - A write is accepted on the edge where wr_valid && wr_ready.
  - If wr_addr < CHANNELS: shadow[wr_addr] <= wr_data and dirty[wr_addr] <= 1. Rewriting a dirty channel overwrites it; last write wins.
  - If wr_addr >= CHANNELS: the write is accepted but dropped, and err is high for the following cycle.
  - wr_valid while wr_ready = 0 is not accepted. The requester holds wr_valid/wr_addr/wr_data until accepted.
- Apply:
  - apply high in IDLE at cycle t moves the block to APPLY for cycles t+1 .. t+CHANNELS, with index = 0 .. CHANNELS-1.
  - At the end of each APPLY cycle, if dirty[index]: active[index] <= shadow[index] and dirty[index] <= 0.
  - Channel i is visible on cfg_out from cycle t+2+i. Non-dirty channels are unchanged.
  - State returns to IDLE at t+CHANNELS+1; done is high in that cycle only. Latency apply -> done is CHANNELS+1 cycles.
  - apply with no dirty channels still runs the full walk and pulses done.
- Simultaneous events:
  - Write and apply in the same IDLE cycle: the write is accepted, sets its dirty bit, and is included in that apply.
  - apply during APPLY is ignored. apply held high re-triggers only after returning to IDLE.
  - done and apply in the same cycle start a new APPLY.
- pending = |dirty, combinational.
- Readback: rd_data <= selected bank[rd_addr] every edge, 1-cycle latency. Out-of-range rd_addr returns 0.
- The index counter wraps to 0 on leaving APPLY. No arithmetic overflow is possible.

Optional Feature:
- Macro CFG_PARAM_BANK_LOCK_EN.
- When defined:
  - Adds input lock (1 bit) and output locked (1 bit).
  - lock high in IDLE sets locked, which stays set until rst_n.
  - While locked: writes are still accepted, shadow/dirty are unchanged, and err pulses for each write; apply is ignored, with no APPLY and no done.
- When not defined: no lock/locked ports; all writes and applies behave as above.

Test Plan:
- Reset with defaults: release rst_n -> cfg_out = 32'h4B32190A and rd_data of addr 2 (active) = 50 after 1 cycle.
- defparam DEFAULTS per instance: u_a = 32'h00000019, u_b = 32'h0000004B -> ch0 reads 25 and 75 respectively after reset.
- Write ch1 = 8'hA5 -> pending = 1, shadow readback = A5, active still 25. Then apply at t -> cfg_out[15:8] = A5 from t+3, done at t+5, pending = 0.
- Write ch3 = 8'h11 and apply in the same cycle -> included in that apply; ch3 = 11 from t+5. A second apply pulsed mid-walk is ignored (exactly one done).
- With CHANNELS=3, ADDR_W=2: write to addr 3 -> wr_ready = 1, err pulses 1 cycle, no shadow change, pending stays 0.
- Assert rst_n low during APPLY index 1 after writing ch0 = 1, ch2 = 2 -> immediate return to DEFAULTS, dirty = 0. With the LOCK_EN variant: lock, then write -> err pulses, apply gives no done.
